j_irq_dec: RTL and testbench

- Interrupt request decoder/responder for the Jerry interrupt path.
- Latches rising edges on 16 request lines into a pending register and masks them with an enable register.
- Produces a registered "any pending" summary and offers one 4-bit vector at a time to the CPU side over a valid/acknowledge handshake, then holds until service completes.
- Sits between the peripheral request wires and the DSP interrupt entry logic. It is the responder end of the 16-line OR summary used elsewhere.

---
 rtl/j_irq_dec_pkg.sv | 27 ++
 rtl/j_irq_dec_if.sv | 29 ++
 rtl/j_pri16.sv | 25 ++
 rtl/j_irq_dec.sv | 95 +++++++++
 tb/tb_j_irq_dec.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/j_irq_dec_pkg.sv
// Shared constants and helpers for the Jerry interrupt decoder.
// State encoding is kept as plain constants for legacy tools.
package j_irq_dec_pkg;

    localparam int NREQ = 16;
    localparam int VW   = 4;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_OFFER   = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    localparam logic [NREQ-1:0] REQ_D_RST = 16'hFFFF;

    // Lowest set index of a 4-bit group; 0 when empty.
    function automatic logic [1:0] lo4(input logic [3:0] v);
        logic [1:0] r;
        priority casez (v)
            4'b???1: r = 2'd0;
            4'b??10: r = 2'd1;
            4'b?100: r = 2'd2;
            4'b1000: r = 2'd3;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/j_irq_dec_if.sv
// CPU-side vector offer / acknowledge / end-of-service bundle.
// slave is the decoder end, master is the CPU end.
interface j_irq_dec_if
    import j_irq_dec_pkg::*;
();

    logic [VW-1:0] vec;
    logic          vec_vld;
    logic          busy;
    logic          ack;
    logic          svc_done;

    modport slave (
        output vec,
        output vec_vld,
        output busy,
        input  ack,
        input  svc_done
    );

    modport master (
        input  vec,
        input  vec_vld,
        input  busy,
        output ack,
        output svc_done
    );

endinterface

// File: rtl/j_pri16.sv
// Lowest-index-first 16->4 priority encoder with found flag.
// Four 4-bit groups are reduced first, then the lowest live group selects.
module j_pri16
    import j_irq_dec_pkg::*;
(
    input  logic [NREQ-1:0] d,
    output logic [VW-1:0]   idx,
    output logic            found
);

    logic [3:0] nr4;
    logic [1:0] nd4 [4];
    logic [1:0] gsel;

    always_comb begin
        for (int g = 0; g < 4; g++) begin
            nr4[g] = |d[4*g +: 4];
            nd4[g] = lo4(d[4*g +: 4]);
        end
        gsel  = lo4(nr4);
        found = |nr4;
        idx   = {gsel, nd4[gsel]};
    end

endmodule

// File: rtl/j_irq_dec.sv
// Jerry interrupt decoder: edge latch, enable mask, pending summary
// and a single-vector offer/ack/service handshake toward the DSP.
module j_irq_dec
    import j_irq_dec_pkg::*;
(
    input  logic            sys_clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] en,
    input  logic            clr_wr,
    input  logic [NREQ-1:0] clr_d,
    output logic [NREQ-1:0] pend_q,
    output logic            pend_any,
    j_irq_dec_if.slave      cpu
);

    logic [NREQ-1:0] req_d;
    logic [NREQ-1:0] rise;
    logic [NREQ-1:0] vec_oh;
    logic [NREQ-1:0] clr_any;
    logic [NREQ-1:0] pend_nxt;
    logic [NREQ-1:0] mp;
    logic [1:0]      state;
    logic [VW-1:0]   vec;
    logic [VW-1:0]   pri_idx;
    logic            vec_vld;
    logic            busy;
    logic            pri_found;
    logic            ack_take;
    logic            keep;

    assign rise     = req & ~req_d;
    assign ack_take = cpu.ack & vec_vld;
    assign vec_oh   = {{(NREQ-1){1'b0}}, 1'b1} << vec;
    assign clr_any  = ({NREQ{clr_wr}} & clr_d)
                    | (ack_take ? vec_oh : '0);
    // Set has priority so an edge coincident with a clear is kept.
    assign pend_nxt = rise | (pend_q & ~clr_any);
    assign mp       = pend_q & en;
    // Offer stays up only while its bit is masked-pending now and next.
    assign keep     = mp[vec] & pend_nxt[vec];

    j_pri16 u_pri (
        .d     (mp),
        .idx   (pri_idx),
        .found (pri_found)
    );

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            req_d    <= REQ_D_RST;
            pend_q   <= '0;
            pend_any <= 1'b0;
            vec      <= '0;
            vec_vld  <= 1'b0;
            busy     <= 1'b0;
            state    <= ST_IDLE;
        end else begin
            req_d    <= req;
            pend_q   <= pend_nxt;
            pend_any <= |mp;
            case (state)
                ST_IDLE: begin
                    if (pri_found) begin
                        vec     <= pri_idx;
                        vec_vld <= 1'b1;
                        state   <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    if (ack_take) begin
                        vec_vld <= 1'b0;
                        busy    <= 1'b1;
                        state   <= ST_SERVICE;
                    end else if (!keep) begin
                        vec_vld <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                ST_SERVICE: begin
                    if (cpu.svc_done) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign cpu.vec     = vec;
    assign cpu.vec_vld = vec_vld;
    assign cpu.busy    = busy;

endmodule

// File: tb/tb_j_irq_dec.sv
// Scoreboard bench for j_irq_dec: expectations are queued with a due
// cycle when stimulus is driven and compared on the falling edge.
module tb_j_irq_dec;
    import j_irq_dec_pkg::*;

    localparam int K_PEND = 0;
    localparam int K_ANY  = 1;
    localparam int K_VEC  = 2;
    localparam int K_VLD  = 3;
    localparam int K_BUSY = 4;

    typedef struct {
        int          due;
        string       tag;
        int          kind;
        logic [15:0] val;
    } exp_t;

    logic            clk;
    logic            reset;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] en;
    logic            clr_wr;
    logic [NREQ-1:0] clr_d;
    logic [NREQ-1:0] pend_q;
    logic            pend_any;

    j_irq_dec_if cpu ();

    j_irq_dec dut (
        .sys_clk  (clk),
        .reset    (reset),
        .req      (req),
        .en       (en),
        .clr_wr   (clr_wr),
        .clr_d    (clr_d),
        .pend_q   (pend_q),
        .pend_any (pend_any),
        .cpu      (cpu)
    );

    exp_t sb[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h want %h (cyc %0d)",
                      tag, got, want, cyc);
    endtask

    function automatic logic [15:0] observed(input int kind);
        logic [15:0] r;
        case (kind)
            K_PEND:  r = pend_q;
            K_ANY:   r = {15'd0, pend_any};
            K_VEC:   r = {12'd0, cpu.vec};
            K_VLD:   r = {15'd0, cpu.vec_vld};
            default: r = {15'd0, cpu.busy};
        endcase
        return r;
    endfunction

    task automatic expect_at(input int d, input string tag,
                             input int kind, input logic [15:0] v);
        exp_t e;
        e.due  = cyc + d;
        e.tag  = tag;
        e.kind = kind;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                chk(sb[i].tag, observed(sb[i].kind), sb[i].val);
                sb.delete(i);
            end
        end
    end

    initial begin
        reset        = 1'b1;
        req          = 16'h0004;
        en           = 16'hFFFF;
        clr_wr       = 1'b0;
        clr_d        = '0;
        cpu.ack      = 1'b0;
        cpu.svc_done = 1'b0;
        tick();
        expect_at(1, "rst_pend", K_PEND, 16'h0000);
        expect_at(1, "rst_any", K_ANY, 16'h0);
        expect_at(1, "rst_vec", K_VEC, 16'h0);
        expect_at(1, "rst_vld", K_VLD, 16'h0);
        expect_at(1, "rst_busy", K_BUSY, 16'h0);
        tick();
        reset = 1'b0;
        expect_at(3, "hi_at_rst_pend", K_PEND, 16'h0000);
        expect_at(3, "hi_at_rst_vld", K_VLD, 16'h0);
        tick(3);

        // req[2] edge: pend at t+1, summary and offer at t+2
        req = 16'h0000;
        tick();
        req = 16'h0004;
        expect_at(1, "e2_pend_t1", K_PEND, 16'h0004);
        expect_at(1, "e2_vld_t1", K_VLD, 16'h0);
        expect_at(1, "e2_any_t1", K_ANY, 16'h0);
        expect_at(2, "e2_any_t2", K_ANY, 16'h1);
        expect_at(2, "e2_vld_t2", K_VLD, 16'h1);
        expect_at(2, "e2_vec_t2", K_VEC, 16'h2);
        tick(2);
        cpu.ack = 1'b1;
        expect_at(1, "e2_ack_busy", K_BUSY, 16'h1);
        expect_at(1, "e2_ack_pend", K_PEND, 16'h0000);
        expect_at(1, "e2_ack_vld", K_VLD, 16'h0);
        tick();
        cpu.ack = 1'b0;
        cpu.svc_done = 1'b1;
        expect_at(1, "e2_done_busy", K_BUSY, 16'h0);
        tick();
        cpu.svc_done = 1'b0;

        // req[5] and req[9] together: 5 first, then 9
        req = 16'h0000;
        tick();
        req = 16'h0220;
        expect_at(1, "p59_pend", K_PEND, 16'h0220);
        expect_at(2, "p59_vec5", K_VEC, 16'h5);
        expect_at(2, "p59_vld", K_VLD, 16'h1);
        tick(2);
        cpu.ack = 1'b1;
        expect_at(1, "p59_ack_pend", K_PEND, 16'h0200);
        expect_at(1, "p59_ack_busy", K_BUSY, 16'h1);
        tick();
        cpu.ack = 1'b0;
        expect_at(1, "p59_svc_vld", K_VLD, 16'h0);
        expect_at(1, "p59_svc_busy", K_BUSY, 16'h1);
        tick();
        cpu.svc_done = 1'b1;
        expect_at(1, "p59_done_busy", K_BUSY, 16'h0);
        tick();
        cpu.svc_done = 1'b0;
        expect_at(1, "p59_vec9", K_VEC, 16'h9);
        expect_at(1, "p59_vld9", K_VLD, 16'h1);
        tick();
        cpu.ack = 1'b1;
        expect_at(1, "p59_ack9_pend", K_PEND, 16'h0000);
        tick();
        cpu.ack = 1'b0;
        cpu.svc_done = 1'b1;
        tick();
        cpu.svc_done = 1'b0;
        req = 16'h0000;
        tick();

        // masked bit 3 waits in pend_q until enabled
        en  = 16'hFFF7;
        req = 16'h0008;
        expect_at(1, "m3_pend", K_PEND, 16'h0008);
        expect_at(2, "m3_any", K_ANY, 16'h0);
        expect_at(2, "m3_vld_a", K_VLD, 16'h0);
        expect_at(3, "m3_vld_b", K_VLD, 16'h0);
        expect_at(3, "m3_pend_b", K_PEND, 16'h0008);
        tick(3);
        en = 16'hFFFF;
        expect_at(2, "m3_en_vec", K_VEC, 16'h3);
        expect_at(2, "m3_en_vld", K_VLD, 16'h1);
        expect_at(2, "m3_en_any", K_ANY, 16'h1);
        tick(2);
        cpu.ack = 1'b1;
        tick();
        cpu.ack = 1'b0;
        cpu.svc_done = 1'b1;
        tick();
        cpu.svc_done = 1'b0;
        req = 16'h0000;
        tick();

        // software clear withdraws the offer of vec 7
        req = 16'h0080;
        expect_at(2, "w7_vec", K_VEC, 16'h7);
        expect_at(2, "w7_vld", K_VLD, 16'h1);
        tick(2);
        clr_wr = 1'b1;
        clr_d  = 16'h0080;
        expect_at(1, "w7_clr_vld", K_VLD, 16'h0);
        expect_at(1, "w7_clr_pend", K_PEND, 16'h0000);
        expect_at(1, "w7_clr_busy", K_BUSY, 16'h0);
        expect_at(2, "w7_idle_vld", K_VLD, 16'h0);
        tick();
        clr_wr = 1'b0;
        clr_d  = '0;
        req    = 16'h0000;
        tick(2);

        // new edge on bit 1 coincides with ack of vec 1
        req = 16'h0002;
        expect_at(2, "s1_vec", K_VEC, 16'h1);
        expect_at(2, "s1_vld", K_VLD, 16'h1);
        tick(2);
        req = 16'h0000;
        tick();
        req = 16'h0002;
        cpu.ack = 1'b1;
        expect_at(1, "s1_set_wins", K_PEND, 16'h0002);
        expect_at(1, "s1_busy", K_BUSY, 16'h1);
        expect_at(1, "s1_ack_vld", K_VLD, 16'h0);
        tick();
        cpu.ack = 1'b0;
        cpu.svc_done = 1'b1;
        tick();
        cpu.svc_done = 1'b0;
        expect_at(1, "s1_reoffer_vec", K_VEC, 16'h1);
        expect_at(1, "s1_reoffer_vld", K_VLD, 16'h1);
        tick();
        cpu.ack = 1'b1;
        tick();
        cpu.ack = 1'b0;

        // reset while in SERVICE, then stray ack/svc_done
        req = 16'h0012;
        expect_at(1, "r_acc_pend", K_PEND, 16'h0010);
        expect_at(1, "r_acc_busy", K_BUSY, 16'h1);
        tick();
        reset = 1'b1;
        expect_at(1, "r_busy", K_BUSY, 16'h0);
        expect_at(1, "r_vld", K_VLD, 16'h0);
        expect_at(1, "r_pend", K_PEND, 16'h0000);
        expect_at(1, "r_any", K_ANY, 16'h0);
        tick();
        reset = 1'b0;
        cpu.ack = 1'b1;
        cpu.svc_done = 1'b1;
        expect_at(1, "stray_busy", K_BUSY, 16'h0);
        expect_at(1, "stray_vld", K_VLD, 16'h0);
        expect_at(1, "stray_pend", K_PEND, 16'h0000);
        tick();
        cpu.ack = 1'b0;
        cpu.svc_done = 1'b0;
        expect_at(2, "stray_vld2", K_VLD, 16'h0);
        expect_at(2, "stray_pend2", K_PEND, 16'h0000);
        expect_at(2, "stray_busy2", K_BUSY, 16'h0);
        tick(4);

        chk("sb_drain", 16'(sb.size()), 16'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
